// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the multicycle (chunk-serial) adder.
package multicycle_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Chunk counter width; a single-stage adder still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned stages);
    return (stages <= 1) ? 1 : $clog2(stages);
  endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational W-bit ripple adder; also exposes the carry into its MSB.
module chunk_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c,
  output logic         cmsb_c
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_c[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout_c = carry[W];
  assign cmsb_c = carry[W-1];

endmodule

// File: rtl/multicycle_adder.sv
// N-bit adder processing W bits per clock with a registered inter-chunk carry.
// Optional signed-overflow output enabled by defining MULTICYCLE_ADDER_OVF_EN.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
`ifdef MULTICYCLE_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);

  localparam int unsigned STAGES = N / W;
  localparam int unsigned CW     = cnt_width(STAGES);

  if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
    $error("multicycle_adder: N must be a non-zero multiple of W with 1 <= W <= N");
  end

  state_t         state;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   chunk_sum_c;
  logic           chunk_cout_c;
  logic [N-1:0]   sum_shift_c;
  logic           last_c;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic           chunk_cmsb_c;
`else
  logic           chunk_cmsb_unused;
`endif

  chunk_adder #(.W(W)) u_chunk (
    .a      (a_sh[W-1:0]),
    .b      (b_sh[W-1:0]),
    .cin    (carry),
    .sum_c  (chunk_sum_c),
    .cout_c (chunk_cout_c),
`ifdef MULTICYCLE_ADDER_OVF_EN
    .cmsb_c (chunk_cmsb_c)
`else
    .cmsb_c (chunk_cmsb_unused)
`endif
  );

  // New chunk enters at the MSB end so the last chunk lands in the top W bits.
  assign sum_shift_c = (sum >> W) | (N'(chunk_sum_c) << (N - W));
  assign last_c      = (cnt == CW'(STAGES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_shift_c;
          carry <= chunk_cout_c;
          a_sh  <= a_sh >> W;
          b_sh  <= b_sh >> W;
          cnt   <= cnt + CW'(1);
          if (last_c) begin
            cout      <= chunk_cout_c;
`ifdef MULTICYCLE_ADDER_OVF_EN
            ovf       <= chunk_cmsb_c ^ chunk_cout_c;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed and random checks of multicycle_adder at N=16 with W=4, W=16 and W=1.
// Overflow checks are compiled in when MULTICYCLE_ADDER_OVF_EN is defined.
module tb_multicycle_adder;

  localparam int unsigned N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [N-1:0] a [3];
  logic [N-1:0] b [3];
  logic [N-1:0] sum [3];
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic [2:0]   ovf;
  logic         last_ovf;
`endif

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] last_sum;
  logic         last_cout;

  // Index 0: W=4, index 1: W=16, index 2: W=1.
  multicycle_adder #(.N(N), .W(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum[0]),
`ifdef MULTICYCLE_ADDER_OVF_EN
    .ovf(ovf[0]),
`endif
    .cout(cout[0]));

  multicycle_adder #(.N(N), .W(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum[1]),
`ifdef MULTICYCLE_ADDER_OVF_EN
    .ovf(ovf[1]),
`endif
    .cout(cout[1]));

  multicycle_adder #(.N(N), .W(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(sum[2]),
`ifdef MULTICYCLE_ADDER_OVF_EN
    .ovf(ovf[2]),
`endif
    .cout(cout[2]));

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs [5] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int stages_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // One full operation: accept, latency check, optional DONE stall, handshake.
  task automatic run_op(input int d, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic cv, input int stall);
    int n;
    int lat;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready[d]), 32'd1);
    a[d] = av;
    b[d] = bv;
    cin[d] = cv;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    a[d] = N'($urandom);
    b[d] = N'($urandom);
    cin[d] = 1'($urandom);
    check("busy_in_ready", 32'(in_ready[d]), 32'd0);
    lat = 0;
    while (!out_valid[d] && lat < 100) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(stages_of(d)));
    last_sum  = sum[d];
    last_cout = cout[d];
`ifdef MULTICYCLE_ADDER_OVF_EN
    last_ovf  = ovf[d];
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_out_valid", 32'(out_valid[d]), 32'd1);
      check("stall_sum", 32'(sum[d]), 32'(last_sum));
      check("stall_cout", 32'(cout[d]), 32'(last_cout));
      check("stall_in_ready", 32'(in_ready[d]), 32'd0);
    end
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check("post_hs_out_valid", 32'(out_valid[d]), 32'd0);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic         rc;
    logic [N:0]   full;
    int           d;

    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    cin = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset state on every instance
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 32'(in_ready[i]), 32'd1);
      check("rst_out_valid", 32'(out_valid[i]), 32'd0);
      check("rst_sum", 32'(sum[i]), 32'd0);
      check("rst_cout", 32'(cout[i]), 32'd0);
`ifdef MULTICYCLE_ADDER_OVF_EN
      check("rst_ovf", 32'(ovf[i]), 32'd0);
`endif
    end

    // Directed vectors on all three widths
    for (int i = 0; i < 3; i++) begin
      for (int v = 0; v < 5; v++) begin
        run_op(i, vecs[v].a, vecs[v].b, vecs[v].cin, 0);
        check("dir_sum", 32'(last_sum), 32'(vecs[v].s));
        check("dir_cout", 32'(last_cout), 32'(vecs[v].co));
`ifdef MULTICYCLE_ADDER_OVF_EN
        check("dir_ovf", 32'(last_ovf), 32'(vecs[v].ov));
`endif
      end
    end

    // Backpressure in DONE with a pending request that must wait for IDLE
    a[0] = 16'h1234;
    b[0] = 16'h1111;
    cin[0] = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp_out_valid", 32'(out_valid[0]), 32'd1);
    check("bp_sum", 32'(sum[0]), 32'h2345);
    a[0] = 16'h0001;
    b[0] = 16'h0002;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
      check("bp_hold_sum", 32'(sum[0]), 32'h2345);
      check("bp_hold_cout", 32'(cout[0]), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("bp_idle_in_ready", 32'(in_ready[0]), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid[0]), 32'd0);
    tick();
    in_valid[0] = 1'b0;
    check("bp_captured", 32'(in_ready[0]), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("bp2_out_valid", 32'(out_valid[0]), 32'd1);
    check("bp2_sum", 32'(sum[0]), 32'h0003);
    check("bp2_cout", 32'(cout[0]), 32'd0);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // Reset during the second RUN cycle discards the operation
    a[0] = 16'h1234;
    b[0] = 16'h1111;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("mid_rst_sum", 32'(sum[0]), 32'd0);
    check("mid_rst_cout", 32'(cout[0]), 32'd0);

    // in_valid together with rst: nothing captured
    a[0] = 16'hAAAA;
    b[0] = 16'h5555;
    in_valid[0] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid[0] = 1'b0;
    tick();
    check("rst_vs_valid_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_vs_valid_out_valid", 32'(out_valid[0]), 32'd0);

    run_op(0, 16'h00FF, 16'h0001, 1'b0, 0);
    check("after_rst_sum", 32'(last_sum), 32'h0100);
    check("after_rst_cout", 32'(last_cout), 32'd0);

    // Random operations against a+b+cin with random DONE stalls
    for (int i = 0; i < 1000; i++) begin
      d = i % 3;
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      run_op(d, ra, rb, rc, int'($urandom_range(0, 3)));
      full = (N + 1)'(ra) + (N + 1)'(rb) + (N + 1)'(rc);
      check("rand_sum", 32'(last_sum), 32'(full[N-1:0]));
      check("rand_cout", 32'(last_cout), 32'(full[N]));
`ifdef MULTICYCLE_ADDER_OVF_EN
      check("rand_ovf", 32'(last_ovf),
            32'((ra[N-1] == rb[N-1]) && (full[N-1] != ra[N-1])));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
Parametrised N-bit adder that processes W bits per clock. It uses a registered carry between chunks, so wide sums use only W-bit ripple logic per cycle. Operands are accepted and results returned on valid/ready handshakes. It is the sequential, area-saving successor to the team's combinational ripple-carry adder, for use where wide adds tolerate multi-cycle latency.

Parameters:
N, 16, operand and sum width in bits; must be a multiple of W (elaboration error otherwise)
W, 4, chunk width added per cycle; 1 <= W <= N; W = N gives a single-chunk operation

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin are presented
in_ready  output  1  block can accept an operation
a  input  N  operand A
b  input  N  operand B
cin  input  1  carry-in to bit 0
out_valid  output  1  sum and cout are valid
out_ready  input  1  consumer accepts the result
sum  output  N  A + B + cin, modulo 2^N
cout  output  1  carry out of bit N-1

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0, carry register=0, chunk counter=0.
- STAGES = N/W. Counter width = max(1, clog2(STAGES)).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture a and b into shift registers and cin into the carry register, clear the counter, go to RUN.
  - a/b/cin are ignored while in_ready=0.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the W-bit chunk adder sums the low W bits of the a/b shift registers plus the carry register.
  - The chunk sum shifts into the result register from the MSB end; the chunk carry-out updates the carry register.
  - a/b shift right by W; the counter increments.
  - On the STAGES-th chunk, go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable until handshake.
  - On out_ready, go to IDLE.
  - out_valid must not drop without out_ready.
- Latency: acceptance edge k, then out_valid is high after edge k+STAGES.
- Minimum initiation interval is STAGES+2 cycles with out_ready tied high. There is no overlap; in_ready is asserted in IDLE only.
- Arithmetic is unsigned modulo 2^N. cout is the final carry register value. The result must be bit-exact with {cout,sum} = a + b + cin.
- Reset in any state returns to IDLE with the reset values on the next edge; any in-flight operation is discarded.
- in_valid asserted together with rst: reset wins and nothing is captured.
- W = N: RUN lasts exactly 1 cycle.

Optional Feature:
- Macro: MULTICYCLE_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed overflow, i.e. carry into bit N-1 XOR carry out of bit N-1.
  - Captured on the final RUN cycle; valid with out_valid and held the same way.
  - Reset value 0.
- Undefined: port absent, no overflow logic; all other behaviour identical.

Decomposition:
- Package multicycle_adder_pkg:
  - state typedef (IDLE/RUN/DONE)
  - localparams for encodings
  - function computing counter width from STAGES
- Sub-module chunk_adder #(W): combinational W-bit ripple adder (a, b, cin -> sum, cout, plus carry into MSB for the overflow feature). It is instantiated once in multicycle_adder.

Test Plan:
- N=16, W=4: a=0x1234, b=0x1111, cin=0 -> sum=0x2345, cout=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all 4 chunks). Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid, sum and cout stay stable and in_ready=0. A new in_valid with a=0x0001, b=0x0002 is not captured until the cycle after IDLE returns, and then yields sum=0x0003.
- Reset during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0. A following 0x00FF+0x0001 yields 0x0100, cout=0.
- Parameter sweep: W=16 and W=1 with N=16. Random 1000 ops against the reference model a+b+cin. Latency must equal N/W cycles; random out_ready stalls are applied.
- MULTICYCLE_ADDER_OVF_EN: 0x7FFF+0x0001 -> ovf=1, cout=0; 0x8000+0x8000 -> sum=0, cout=1, ovf=1; 0xFFFF+0x0001 -> ovf=0.
